ldiv_result_buf: RTL and testbench

Result buffer and issue-credit tracker that sits directly downstream of the pipelined long divider. The divider has a fixed latency and cannot stall. This block therefore does two jobs: it captures every quotient/remainder pair the divider emits into a first-word-fall-through FIFO, and it tells the upstream requester when issuing another divide is safe. It then presents results to the consumer with a valid/ready handshake.

---
 rtl/ldiv_result_buf.sv | 110 +++++++++++
 tb/tb_ldiv_result_buf.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ldiv_result_buf.sv
// Result FIFO (first-word-fall-through) and issue-credit tracker placed behind
// the fixed-latency, non-stallable pipelined long divider.
module ldiv_result_buf #(
  parameter int NUMERATOR_WIDTH = 10,
  parameter int QUOTIENT_WIDTH  = 10,
  parameter int DEPTH           = 4
) (
  input  logic                       clk,
  input  logic                       resetb,
  input  logic                       issue,
  input  logic                       res_valid,
  input  logic [QUOTIENT_WIDTH-1:0]  res_quotient,
  input  logic [NUMERATOR_WIDTH-1:0] res_remainder,
  output logic                       issue_ok,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [QUOTIENT_WIDTH-1:0]  out_quotient,
  output logic [NUMERATOR_WIDTH-1:0] out_remainder,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic [$clog2(DEPTH):0]     inflight,
  output logic                       err
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = QUOTIENT_WIDTH + NUMERATOR_WIDTH;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] INFL_MAX = CW'(2 * DEPTH - 1);

  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] res_word;
  logic [EW-1:0] head;
  logic [EW-1:0] head_nxt;
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [PW-1:0] rptr_nxt;
  logic [CW-1:0] occ_nxt;
  logic [CW-1:0] infl_nxt;
  logic [CW:0]   credit_sum;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          err_set;

  assign res_word   = {res_quotient, res_remainder};
  assign full       = (occupancy == DEPTH_C);
  assign empty      = (occupancy == '0);
  assign out_valid  = ~empty;
  assign push       = res_valid & ~full;
  assign pop        = out_valid & out_ready;
  assign rptr_nxt   = pop ? rptr + PW'(1) : rptr;

  // Credit counts both stored and still-in-the-divider results, from registers only.
  assign credit_sum = {1'b0, occupancy} + {1'b0, inflight};
  assign issue_ok   = (credit_sum < {1'b0, DEPTH_C});

  assign err_set = (issue & ~issue_ok) | (res_valid & full) | (res_valid & (inflight == '0));

  always_comb begin
    occ_nxt = occupancy;
    if (push && !pop) begin
      occ_nxt = occupancy + CW'(1);
    end else if (pop && !push) begin
      occ_nxt = occupancy - CW'(1);
    end
  end

  always_comb begin
    infl_nxt = inflight;
    if (issue && !res_valid) begin
      if (inflight != INFL_MAX) infl_nxt = inflight + CW'(1);
    end else if (res_valid && !issue) begin
      if (inflight != '0) infl_nxt = inflight - CW'(1);
    end
  end

  // Registered head: bypass the incoming word when it lands in the slot about
  // to be presented, and hold the last value whenever the FIFO goes empty.
  always_comb begin
    head_nxt = head;
    if (occ_nxt != '0) begin
      head_nxt = (push && (wptr == rptr_nxt)) ? res_word : mem[rptr_nxt];
    end
  end

  assign {out_quotient, out_remainder} = head;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      wptr      <= '0;
      rptr      <= '0;
      occupancy <= '0;
      inflight  <= '0;
      head      <= '0;
      err       <= 1'b0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      rptr      <= rptr_nxt;
      occupancy <= occ_nxt;
      inflight  <= infl_nxt;
      head      <= head_nxt;
      if (err_set) err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= res_word;
  end

endmodule

// File: tb/tb_ldiv_result_buf.sv
// Scoreboard bench for ldiv_result_buf: a bench-side divider pipeline feeds the
// DUT, a counter/queue reference model predicts state, a monitor checks outputs.
module tb_ldiv_result_buf;
  localparam int NW = 10;
  localparam int QW = 10;
  localparam int D  = 4;

  typedef struct packed {
    logic [QW-1:0] q;
    logic [NW-1:0] r;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic resetb;

  logic          issue, res_valid, out_ready, issue_ok, out_valid, err;
  logic [QW-1:0] res_quotient, out_quotient;
  logic [NW-1:0] res_remainder, out_remainder;
  logic [2:0]    occupancy, inflight;

  logic          issue8, res_valid8, out_ready8, issue_ok8, out_valid8, err8;
  logic [3:0]    res_q8, res_r8, out_q8, out_r8, occ8, infl8;

  ldiv_result_buf #(.NUMERATOR_WIDTH(NW), .QUOTIENT_WIDTH(QW), .DEPTH(D)) u_dut (
    .clk(clk), .resetb(resetb), .issue(issue), .res_valid(res_valid),
    .res_quotient(res_quotient), .res_remainder(res_remainder), .issue_ok(issue_ok),
    .out_valid(out_valid), .out_ready(out_ready), .out_quotient(out_quotient),
    .out_remainder(out_remainder), .occupancy(occupancy), .inflight(inflight), .err(err)
  );

  ldiv_result_buf #(.NUMERATOR_WIDTH(4), .QUOTIENT_WIDTH(4), .DEPTH(8)) u_dut8 (
    .clk(clk), .resetb(resetb), .issue(issue8), .res_valid(res_valid8),
    .res_quotient(res_q8), .res_remainder(res_r8), .issue_ok(issue_ok8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_quotient(out_q8),
    .out_remainder(out_r8), .occupancy(occ8), .inflight(infl8), .err(err8)
  );

  int checks = 0;
  int failures = 0;
  int n_pop = 0;
  int n_pop8 = 0;

  // reference model of the DEPTH=4 instance
  int   m_occ, m_infl;
  bit   m_err;
  res_t sb[$];
  logic [7:0] sb8[$];

  // bench-side divider pipeline
  int   lat;
  bit   pipe_v[8];
  res_t pipe_d[8];
  bit   p8v[5];
  logic [7:0] p8d[5];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check("issue_ok", int'(issue_ok), int'((m_occ + m_infl) < D));
    check("occupancy", int'(occupancy), m_occ);
    check("inflight", int'(inflight), m_infl);
    check("out_valid", int'(out_valid), int'(m_occ != 0));
    check("err", int'(err), int'(m_err));
  endtask

  task automatic drive(input bit iss, input int num, input int den, input bit rdy,
                       input bit inj = 1'b0, input int inj_q = 0, input int inj_r = 0);
    res_t rv;
    res_t nw;
    bit   rvld, m_ok, m_full, m_push, m_pop;
    rvld = pipe_v[lat-1];
    rv   = pipe_d[lat-1];
    for (int k = 7; k > 0; k--) begin
      pipe_v[k] = pipe_v[k-1];
      pipe_d[k] = pipe_d[k-1];
    end
    nw = '0;
    if (iss) begin
      nw.q = QW'(num / den);
      nw.r = NW'(num % den);
    end
    pipe_v[0] = iss;
    pipe_d[0] = nw;
    if (inj) begin
      rvld = 1'b1;
      rv.q = QW'(inj_q);
      rv.r = NW'(inj_r);
    end
    issue = iss;
    res_valid = rvld;
    res_quotient = rv.q;
    res_remainder = rv.r;
    out_ready = rdy;
    m_ok   = (m_occ + m_infl) < D;
    m_full = (m_occ == D);
    if ((iss && !m_ok) || (rvld && m_full) || (rvld && m_infl == 0)) m_err = 1'b1;
    m_push = rvld && !m_full;
    m_pop  = (m_occ != 0) && rdy;
    if (m_push) sb.push_back(rv);
    if (m_push && !m_pop) m_occ++;
    else if (m_pop && !m_push) m_occ--;
    if (iss && !rvld) begin
      if (m_infl < 2 * D - 1) m_infl++;
    end else if (rvld && !iss) begin
      if (m_infl > 0) m_infl--;
    end
  endtask

  task automatic apply_reset();
    issue = 1'b0; res_valid = 1'b0; out_ready = 1'b0; res_quotient = '0; res_remainder = '0;
    issue8 = 1'b0; res_valid8 = 1'b0; out_ready8 = 1'b0; res_q8 = '0; res_r8 = '0;
    resetb = 1'b0;
    #1;
    m_occ = 0; m_infl = 0; m_err = 1'b0;
    sb.delete();
    for (int k = 0; k < 8; k++) begin
      pipe_v[k] = 1'b0;
      pipe_d[k] = '0;
    end
    check("rst_occupancy", int'(occupancy), 0);
    check("rst_inflight", int'(inflight), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_err", int'(err), 0);
    check("rst_issue_ok", int'(issue_ok), 1);
    check("rst_out_quotient", int'(out_quotient), 0);
    check("rst_out_remainder", int'(out_remainder), 0);
    @(negedge clk);
    resetb = 1'b1;
  endtask

  initial begin : mon4
    res_t e;
    forever begin
      @(negedge clk);
      if (resetb === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result: got q=%0d r=%0d expected no result", out_quotient, out_remainder);
        end else begin
          e = sb.pop_front();
          check("out_quotient", int'(out_quotient), int'(e.q));
          check("out_remainder", int'(out_remainder), int'(e.r));
          n_pop++;
        end
      end
    end
  end

  initial begin : mon8
    logic [7:0] e8;
    forever begin
      @(negedge clk);
      if (resetb === 1'b1 && out_valid8 === 1'b1 && out_ready8 === 1'b1) begin
        if (sb8.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL stream_unexpected: got q=%0d r=%0d expected no result", out_q8, out_r8);
        end else begin
          e8 = sb8.pop_front();
          check("stream_quotient", int'(out_q8), int'(e8[7:4]));
          check("stream_remainder", int'(out_r8), int'(e8[3:0]));
          n_pop8++;
        end
      end
    end
  end

  initial begin : stim
    bit iss;
    int n_iss;
    int base;
    resetb = 1'b1;
    lat = 1;
    issue = 1'b0; res_valid = 1'b0; out_ready = 1'b0; res_quotient = '0; res_remainder = '0;
    issue8 = 1'b0; res_valid8 = 1'b0; out_ready8 = 1'b0; res_q8 = '0; res_r8 = '0;
    #2;
    apply_reset();

    // streaming: DEPTH=8, 4-bit widths, latency 5, numerators 0..15 over 3
    for (int k = 0; k < 5; k++) begin
      p8v[k] = 1'b0;
      p8d[k] = '0;
    end
    for (int c = 0; c < 26; c++) begin
      @(posedge clk);
      #1;
      if (c < 16) begin
        check("stream_issue_ok", int'(issue_ok8), 1);
        sb8.push_back({4'(c / 3), 4'(c % 3)});
      end
      res_valid8 = p8v[4];
      res_q8 = p8d[4][7:4];
      res_r8 = p8d[4][3:0];
      for (int k = 4; k > 0; k--) begin
        p8v[k] = p8v[k-1];
        p8d[k] = p8d[k-1];
      end
      p8v[0] = (c < 16);
      p8d[0] = {4'(c / 3), 4'(c % 3)};
      issue8 = (c < 16);
      out_ready8 = 1'b1;
    end
    issue8 = 1'b0;
    res_valid8 = 1'b0;
    check("stream_count", n_pop8, 16);
    check("stream_err", int'(err8), 0);
    check("stream_occ", int'(occ8), 0);
    check("stream_left", sb8.size(), 0);

    // random legal traffic, latency 3
    lat = 3;
    for (int c = 0; c < 300; c++) begin
      tick();
      iss = issue_ok && ($urandom_range(0, 3) != 0);
      drive(iss, int'($urandom_range(0, 1023)), int'($urandom_range(1, 1023)),
            $urandom_range(0, 1) == 1);
    end
    for (int c = 0; c < 8; c++) begin
      tick();
      drive(1'b0, 0, 1, 1'b1);
    end
    tick();
    check("rand_drained", sb.size(), 0);
    drive(1'b0, 0, 1, 1'b0);

    // backpressure: latency 5, consumer stalled
    apply_reset();
    lat = 5;
    n_iss = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      iss = issue_ok;
      if (iss) n_iss++;
      drive(iss, 50 + c, 5, 1'b0);
    end
    tick();
    check("bp_issues", n_iss, 4);
    check("bp_occupancy", int'(occupancy), 4);
    check("bp_issue_ok_low", int'(issue_ok), 0);
    drive(1'b0, 0, 1, 1'b1);
    for (int c = 0; c < 4; c++) begin
      tick();
      drive(1'b0, 0, 1, 1'b1);
    end
    tick();
    check("bp_drained", int'(occupancy), 0);
    check("bp_issue_ok_back", int'(issue_ok), 1);
    check("bp_left", sb.size(), 0);
    drive(1'b0, 0, 1, 1'b0);

    // issue, result and pop in the same cycle at occupancy 2, inflight 1
    apply_reset();
    lat = 3;
    tick(); drive(1'b1, 100, 7, 1'b0);
    tick(); drive(1'b1, 200, 7, 1'b0);
    tick(); drive(1'b1, 300, 7, 1'b0);
    tick(); drive(1'b0, 0, 1, 1'b0);
    tick(); drive(1'b0, 0, 1, 1'b0);
    tick();
    check("sim_pre_occ", int'(occupancy), 2);
    check("sim_pre_infl", int'(inflight), 1);
    drive(1'b1, 400, 7, 1'b1);
    tick();
    check("sim_occ", int'(occupancy), 2);
    check("sim_infl", int'(inflight), 1);
    check("sim_head_q", int'(out_quotient), 28);
    check("sim_head_r", int'(out_remainder), 4);
    drive(1'b0, 0, 1, 1'b1);
    for (int c = 0; c < 6; c++) begin
      tick();
      drive(1'b0, 0, 1, 1'b1);
    end
    tick();
    check("sim_left", sb.size(), 0);
    drive(1'b0, 0, 1, 1'b0);

    // issue without credit, then the extra result overflows the FIFO
    apply_reset();
    lat = 8;
    for (int k = 0; k < 4; k++) begin
      tick();
      drive(1'b1, 30 + k, 3, 1'b0);
    end
    tick();
    check("ovf_issue_ok", int'(issue_ok), 0);
    check("ovf_err_before", int'(err), 0);
    drive(1'b1, 99, 3, 1'b0);
    tick();
    check("ovf_err", int'(err), 1);
    drive(1'b0, 0, 1, 1'b0);
    for (int c = 0; c < 8; c++) begin
      tick();
      drive(1'b0, 0, 1, 1'b0);
    end
    tick();
    check("ovf_occ", int'(occupancy), 4);
    check("ovf_infl", int'(inflight), 0);
    drive(1'b0, 0, 1, 1'b1);
    for (int c = 0; c < 5; c++) begin
      tick();
      drive(1'b0, 0, 1, 1'b1);
    end
    tick();
    check("ovf_left", sb.size(), 0);
    drive(1'b0, 0, 1, 1'b0);

    // unexpected result with inflight 0 while full
    apply_reset();
    lat = 2;
    for (int k = 0; k < 4; k++) begin
      tick();
      drive(1'b1, 500 + k * 10, 9, 1'b0);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      drive(1'b0, 0, 1, 1'b0);
    end
    tick();
    check("full_pre_occ", int'(occupancy), 4);
    check("full_pre_infl", int'(inflight), 0);
    check("full_pre_err", int'(err), 0);
    drive(1'b0, 0, 1, 1'b0, 1'b1, 999, 7);
    tick();
    check("full_drop_occ", int'(occupancy), 4);
    check("full_drop_err", int'(err), 1);
    drive(1'b0, 0, 1, 1'b1);
    for (int c = 0; c < 4; c++) begin
      tick();
      drive(1'b0, 0, 1, 1'b1);
    end
    tick();
    check("full_left", sb.size(), 0);
    drive(1'b0, 0, 1, 1'b0);

    // asynchronous reset mid-run with three stored entries and err set
    for (int k = 0; k < 3; k++) begin
      tick();
      drive(1'b1, 70 + k, 4, 1'b0);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      drive(1'b0, 0, 1, 1'b0);
    end
    tick();
    check("pre_reset_occ", int'(occupancy), 3);
    check("pre_reset_err", int'(err), 1);
    #2;
    apply_reset();

    // pointer wrap: ten single-entry transfers, quotient 1..10
    lat = 2;
    base = n_pop;
    for (int i = 1; i <= 10; i++) begin
      tick(); drive(1'b1, i, 1, 1'b1);
      tick(); drive(1'b0, 0, 1, 1'b1);
      tick(); drive(1'b0, 0, 1, 1'b1);
      tick(); drive(1'b0, 0, 1, 1'b1);
    end
    tick();
    check("wrap_count", n_pop - base, 10);
    check("wrap_left", sb.size(), 0);
    drive(1'b0, 0, 1, 1'b0);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
